// File: rtl/cram_writer_pkg.sv
// Shared CRAM write-side definitions: geometry defaults, fill FSM states, grant codes.
// Also used by the video output path and the CRAM instantiation.
package cram_writer_pkg;

    localparam int CRAM_AW = 8;
    localparam int CRAM_DW = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_st_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_Z80  = 2'd1,
        GNT_DMA  = 2'd2,
        GNT_FILL = 2'd3
    } gnt_e;

endpackage

// File: rtl/cram_fill_seq.sv
// Palette fill sequencer: walks every CRAM entry once, writing a single latched value.
// Advances only on slots the top-level arbiter grants to it.
module cram_fill_seq
    import cram_writer_pkg::*;
#(
    parameter int AW = CRAM_AW,
    parameter int DW = CRAM_DW
) (
    input  logic          clk,
    input  logic          res,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_val,
    input  logic          fill_gnt,
    output logic          fill_req,
    output logic [AW-1:0] fill_addr,
    output logic [DW-1:0] fill_data,
    output logic          busy
);

    fill_st_e      state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] val, val_nxt;

    always_ff @(posedge clk) begin
        if (res) begin
            state <= ST_IDLE;
            cnt   <= '0;
            val   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            val   <= val_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        val_nxt   = val;
        case (state)
            ST_IDLE: begin
                if (fill_start) begin
                    state_nxt = ST_FILL;
                    cnt_nxt   = '0;
                    val_nxt   = fill_val;
                end
            end
            ST_FILL: begin
                // fill_start is deliberately ignored here; the value stays as first latched
                if (fill_gnt) begin
                    cnt_nxt = cnt + AW'(1);
                    if (cnt == {AW{1'b1}})
                        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign fill_req  = (state == ST_FILL);
    assign busy      = (state == ST_FILL);
    assign fill_addr = cnt;
    assign fill_data = val;

endmodule

// File: rtl/cram_writer.sv
// CRAM write-port master: merges Z80 byte writes, DMA word writes and the palette fill
// into one registered write port with fixed priority Z80 > DMA > fill.
module cram_writer
    import cram_writer_pkg::*;
#(
    parameter int AW = CRAM_AW,
    parameter int DW = CRAM_DW
) (
    input  logic          clk,
    input  logic          res,
    input  logic          zw_we,
    input  logic [AW:0]   zw_addr,
    input  logic [7:0]    zw_data,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_data,
    output logic          dma_ack,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic [AW-1:0] cram_addr,
    output logic [DW-1:0] cram_data,
    output logic          cram_we
);

    logic [7:0]    lo_byte;
    logic          z80_commit, z80_lo_load, dma_win;
    logic          fill_req, fill_gnt;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    gnt_e          gnt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] data_nxt;

    cram_fill_seq #(.AW(AW), .DW(DW)) u_fill (
        .clk        (clk),
        .res        (res),
        .fill_start (fill_start),
        .fill_val   (fill_val),
        .fill_gnt   (fill_gnt),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .busy       (busy)
    );

    always_comb begin
        z80_commit  = zw_we & zw_addr[0];
        z80_lo_load = zw_we & ~zw_addr[0];
        // a request seen while its ack is out is the same request, not a new one
        dma_win     = dma_req & ~dma_ack;

        gnt = GNT_NONE;
        if (z80_commit)    gnt = GNT_Z80;
        else if (dma_win)  gnt = GNT_DMA;
        else if (fill_req) gnt = GNT_FILL;

        fill_gnt = (gnt == GNT_FILL);

        addr_nxt = cram_addr;
        data_nxt = cram_data;
        case (gnt)
            GNT_Z80: begin
                addr_nxt = zw_addr[AW:1];
                data_nxt = DW'({zw_data, lo_byte});
            end
            GNT_DMA: begin
                addr_nxt = dma_addr;
                data_nxt = dma_data;
            end
            GNT_FILL: begin
                addr_nxt = fill_addr;
                data_nxt = fill_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            lo_byte   <= '0;
            cram_we   <= 1'b0;
            cram_addr <= '0;
            cram_data <= '0;
            dma_ack   <= 1'b0;
        end else begin
            if (z80_lo_load)
                lo_byte <= zw_data;
            cram_we   <= (gnt != GNT_NONE);
            dma_ack   <= (gnt == GNT_DMA);
            cram_addr <= addr_nxt;
            cram_data <= data_nxt;
        end
    end

endmodule

// File: tb/tb_cram_writer.sv
// Directed bench for cram_writer: Z80 byte pairing, DMA handshake, fill, arbitration, reset.
module tb_cram_writer;

    logic        clk = 1'b0;
    logic        res;
    logic        zw_we;
    logic [8:0]  zw_addr;
    logic [7:0]  zw_data;
    logic        dma_req;
    logic [7:0]  dma_addr;
    logic [15:0] dma_data;
    logic        dma_ack;
    logic        fill_start;
    logic [15:0] fill_val;
    logic        busy;
    logic [7:0]  cram_addr;
    logic [15:0] cram_data;
    logic        cram_we;

    int checks = 0;
    int failures = 0;

    cram_writer dut (
        .clk        (clk),
        .res        (res),
        .zw_we      (zw_we),
        .zw_addr    (zw_addr),
        .zw_data    (zw_data),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_data   (dma_data),
        .dma_ack    (dma_ack),
        .fill_start (fill_start),
        .fill_val   (fill_val),
        .busy       (busy),
        .cram_addr  (cram_addr),
        .cram_data  (cram_data),
        .cram_we    (cram_we)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        res = 1'b1; zw_we = 1'b0; zw_addr = '0; zw_data = '0;
        dma_req = 1'b0; dma_addr = '0; dma_data = '0;
        fill_start = 1'b0; fill_val = '0;

        // reset state
        step(); step();
        chk("rst_we", cram_we, 0);
        chk("rst_addr", cram_addr, 0);
        chk("rst_data", cram_data, 0);
        chk("rst_ack", dma_ack, 0);
        chk("rst_busy", busy, 0);
        res = 1'b0;
        step();

        // Z80 byte pair: low byte latches only, high byte commits
        zw_we = 1'b1; zw_addr = 9'h00A; zw_data = 8'h34;
        step();
        chk("z80_lo_no_we", cram_we, 0);
        zw_addr = 9'h00B; zw_data = 8'h12;
        step();
        zw_we = 1'b0;
        chk("z80_we", cram_we, 1);
        chk("z80_addr", cram_addr, 8'h05);
        chk("z80_data", cram_data, 16'h1234);
        step();
        chk("z80_we_pulse", cram_we, 0);

        // DMA: ack with write, held request spaced two cycles apart
        dma_req = 1'b1; dma_addr = 8'h80; dma_data = 16'h7FFF;
        step();
        chk("dma_ack1", dma_ack, 1);
        chk("dma_we1", cram_we, 1);
        chk("dma_addr1", cram_addr, 8'h80);
        chk("dma_data1", cram_data, 16'h7FFF);
        step();
        chk("dma_gap_we", cram_we, 0);
        chk("dma_gap_ack", dma_ack, 0);
        step();
        chk("dma_ack2", dma_ack, 1);
        chk("dma_we2", cram_we, 1);
        dma_req = 1'b0;
        step();
        chk("dma_idle_we", cram_we, 0);

        // DMA loses to Z80 commit, then withdraws: no write
        zw_we = 1'b1; zw_addr = 9'h043; zw_data = 8'h56;
        dma_req = 1'b1; dma_addr = 8'h11; dma_data = 16'hBEEF;
        step();
        zw_we = 1'b0; dma_req = 1'b0;
        chk("wd_z80_addr", cram_addr, 8'h21);
        chk("wd_z80_data", cram_data, 16'h5634);
        chk("wd_no_ack", dma_ack, 0);
        step();
        chk("wd_no_we", cram_we, 0);
        chk("wd_no_ack2", dma_ack, 0);

        // uncontended fill of zero
        fill_val = 16'h0000; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        chk("fill0_busy_start", busy, 1);
        chk("fill0_no_we_start", cram_we, 0);
        for (int i = 0; i < 256; i++) begin
            step();
            chk("fill0_we", cram_we, 1);
            chk("fill0_addr", cram_addr, i);
            chk("fill0_data", cram_data, 16'h0000);
            chk("fill0_busy", busy, (i == 255) ? 0 : 1);
        end
        step();
        chk("fill0_done_we", cram_we, 0);

        // fill_start during fill is ignored
        fill_val = 16'h1ABC; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i == 10) begin fill_start = 1'b1; fill_val = 16'h0F0F; end
            if (i == 11) fill_start = 1'b0;
            step();
            chk("refill_addr", cram_addr, i);
            chk("refill_data", cram_data, 16'h1ABC);
        end
        step();
        chk("refill_idle_busy", busy, 0);

        // contention: Z80 + DMA + fill in one cycle
        fill_val = 16'h2222; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        step();
        chk("cont_f0", cram_addr, 0);
        step();
        chk("cont_f1", cram_addr, 1);
        zw_we = 1'b1; zw_addr = 9'h067; zw_data = 8'hAB;
        dma_req = 1'b1; dma_addr = 8'h44; dma_data = 16'h5555;
        step();
        zw_we = 1'b0;
        chk("cont_z80_addr", cram_addr, 8'h33);
        chk("cont_z80_data", cram_data, 16'hAB34);
        chk("cont_z80_noack", dma_ack, 0);
        step();
        dma_req = 1'b0;
        chk("cont_dma_ack", dma_ack, 1);
        chk("cont_dma_addr", cram_addr, 8'h44);
        chk("cont_dma_data", cram_data, 16'h5555);
        for (int i = 2; i < 256; i++) begin
            step();
            chk("cont_fill_we", cram_we, 1);
            chk("cont_fill_addr", cram_addr, i);
            chk("cont_fill_data", cram_data, 16'h2222);
        end
        chk("cont_busy_end", busy, 0);
        step();

        // reset mid-fill
        fill_val = 16'h3333; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int j = 0; j < 100; j++) step();
        chk("rstf_at99", cram_addr, 99);
        res = 1'b1;
        step();
        chk("rstf_we", cram_we, 0);
        chk("rstf_busy", busy, 0);
        res = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("rstf_quiet_we", cram_we, 0);
            chk("rstf_quiet_busy", busy, 0);
        end
        fill_val = 16'h4444; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            chk("rstf_re_addr", cram_addr, i);
            chk("rstf_re_data", cram_data, 16'h4444);
        end
        chk("rstf_re_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
